// File: rtl/spi_dds_pkg.sv
// Shared types and elaboration helpers for the DDS SPI master.
package spi_dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // SCLK edge positions inside one CLK_DIV_EVEN period
  function automatic int quarter(input int div);
    return div / 4;
  endfunction

  function automatic int three_qtrs(input int div);
    return (3 * div) / 4;
  endfunction

  function automatic int cs_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_dds_clk_div.sv
// Bit-rate tick generator and mode-0 SCLK; SCLK is held low whenever no chip select is active.
module spi_clk_div
  import spi_dds_pkg::*;
#(
  parameter int CLK_DIV_EVEN = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_cs_active,
  output logic o_ena,
  output logic o_sclk
);

  localparam int CNT_W = $clog2(CLK_DIV_EVEN);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tgl;

  assign o_ena  = (r_cnt == CNT_W'(CLK_DIV_EVEN - 1));
  assign w_tgl  = (r_cnt == CNT_W'(quarter(CLK_DIV_EVEN))) ||
                  (r_cnt == CNT_W'(three_qtrs(CLK_DIV_EVEN)));
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= o_ena ? '0 : r_cnt + CNT_W'(1);
      if (!i_cs_active)
        r_sclk <= 1'b0;
      else if (w_tgl)
        r_sclk <= ~r_sclk;
    end
  end

endmodule

// File: rtl/spi_master_dds.sv
// SPI master for DDS/serial-register devices: FIFO-fed frames, read-phase MOSI release, io_update.
// Build option: SPI_IO_UPDATE_EN adds the UPDATE state and the io_update strobe after write frames.
//
//  state     | meaning
//  ST_IDLE   | no frame; waits for a command word
//  ST_SHIFT  | shifting a word out, seamless reload at word boundary
//  ST_UPDATE | one ena period of io_update after a write frame
module spi_master_dds
  import spi_dds_pkg::*;
#(
  parameter int CLK_DIV_EVEN = 8,
  parameter int DATA_W       = 8,
  parameter int N_CS         = 1,
  parameter int HZ_BITS      = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_have_data,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [cs_w(N_CS)-1:0]   i_cs_sel,
  output logic                    o_rdreq,
  output logic [DATA_W-1:0]       o_miso_reg,
  output logic                    o_wrreq,
  output logic                    o_busy,
  output logic                    o_sclk,
  output logic [N_CS-1:0]         o_n_cs,
  output logic                    o_mosi,
  input  logic                    i_miso,
  output logic                    o_io_update,
  output logic                    o_high_z
);

  localparam int CSW   = cs_w(N_CS);
  localparam int BIT_W = $clog2(DATA_W);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_miso;
  logic [BIT_W-1:0]  r_cnt_bit;
  logic [7:0]        r_bits;
  logic              r_read;
  logic              r_rdreq;
  logic              r_wrreq;
  logic [N_CS-1:0]   r_n_cs;
  logic              w_ena;
  logic              w_sclk;
  logic              w_cs_active;
  logic              w_last;

  assign w_cs_active = ~&r_n_cs;
  assign w_last      = (r_cnt_bit == BIT_W'(DATA_W - 1));

  spi_clk_div #(.CLK_DIV_EVEN(CLK_DIV_EVEN)) u_clk_div (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_cs_active (w_cs_active),
    .o_ena       (w_ena),
    .o_sclk      (w_sclk)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_miso    <= '0;
      r_cnt_bit <= '0;
      r_bits    <= '0;
      r_read    <= 1'b0;
      r_rdreq   <= 1'b0;
      r_wrreq   <= 1'b0;
      r_n_cs    <= '1;
    end else begin
      r_rdreq <= 1'b0;
      r_wrreq <= 1'b0;
      if (w_ena) begin
        r_miso <= {r_miso[DATA_W-2:0], i_miso};
        case (r_state)
          ST_IDLE: begin
            if (i_have_data) begin
              r_shift   <= i_data;
              r_cnt_bit <= '0;
              r_bits    <= '0;
              r_rdreq   <= 1'b1;
              r_read    <= i_data[DATA_W-1];
              // an out-of-range select matches no line, so the frame runs with every n_cs high
              for (int i = 0; i < N_CS; i++)
                r_n_cs[i] <= (CSW'(i) != i_cs_sel);
              r_state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (r_bits != 8'hFF)
              r_bits <= r_bits + 8'd1;
            if (w_last) begin
              r_wrreq <= 1'b1;
              if (i_have_data) begin
                r_shift   <= i_data;
                r_cnt_bit <= '0;
                r_rdreq   <= 1'b1;
              end else begin
                r_n_cs <= '1;
                r_read <= 1'b0;
                r_bits <= '0;
                r_shift <= '0;
`ifdef SPI_IO_UPDATE_EN
                r_state <= r_read ? ST_IDLE : ST_UPDATE;
`else
                r_state <= ST_IDLE;
`endif
              end
            end else begin
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
              r_cnt_bit <= r_cnt_bit + BIT_W'(1);
            end
          end
`ifdef SPI_IO_UPDATE_EN
          ST_UPDATE: r_state <= ST_IDLE;
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SPI_IO_UPDATE_EN
  logic r_io_update;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_io_update <= 1'b0;
    else if (w_ena)
      r_io_update <= (r_state == ST_UPDATE);
  end

  assign o_io_update = r_io_update;
`else
  assign o_io_update = 1'b0;
`endif

  assign o_rdreq    = r_rdreq;
  assign o_wrreq    = r_wrreq;
  assign o_miso_reg = r_miso;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_sclk     = w_sclk;
  assign o_n_cs     = r_n_cs;
  assign o_mosi     = r_shift[DATA_W-1];
  assign o_high_z   = r_read && (r_bits >= 8'(HZ_BITS));

endmodule
